// File: rtl/vx_div_share_sched.sv
// Round-robin scheduler sharing one fixed-latency iterative divider among NUM_REQS requesters.
// One operation is in flight at a time; the response is tagged with the owning requester index.
module vx_div_share_sched #(
  parameter int unsigned NUM_REQS = 4,
  parameter int unsigned DATAW    = 128,
  parameter int unsigned RESW     = 64,
  parameter int unsigned TAGW     = 16,
  parameter int unsigned LATENCY  = 33,
  localparam int unsigned IDXW    = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_REQS-1:0]      req_valid,
  input  logic [NUM_REQS*DATAW-1:0] req_data,
  input  logic [NUM_REQS*TAGW-1:0] req_tag,
  output logic [NUM_REQS-1:0]      req_ready,
  output logic                     div_strobe,
  output logic [DATAW-1:0]         div_data,
  input  logic [RESW-1:0]          div_result,
  output logic                     rsp_valid,
  output logic [IDXW-1:0]          rsp_idx,
  output logic [TAGW-1:0]          rsp_tag,
  output logic [RESW-1:0]          rsp_data,
  input  logic                     rsp_ready
);

  localparam int unsigned CNTW = $clog2(LATENCY);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e              state;
  logic [IDXW-1:0]     rr_ptr;
  logic [CNTW-1:0]     cnt;

  logic [NUM_REQS-1:0] grant;
  logic [IDXW-1:0]     grant_idx;
  logic [IDXW-1:0]     scan_idx;
  logic                can_accept;
  logic                fire;

  // Round-robin search starting at rr_ptr; first valid requester wins.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    scan_idx  = '0;
    for (int unsigned i = 0; i < NUM_REQS; i++) begin
      scan_idx = IDXW'((32'(rr_ptr) + i) % NUM_REQS);
      if ((grant == '0) && req_valid[scan_idx]) begin
        grant[scan_idx] = 1'b1;
        grant_idx       = scan_idx;
      end
    end
  end

  // A new op may launch when idle, or in the same cycle the pending response is taken.
  assign can_accept = !reset && ((state == ST_IDLE) || ((state == ST_DONE) && rsp_ready));
  assign req_ready  = grant & {NUM_REQS{can_accept}};
  assign fire       = |(req_valid & req_ready);
  assign div_strobe = fire;
  assign div_data   = req_data[32'(grant_idx) * DATAW +: DATAW];

  // The divider holds its result until the next strobe, which cannot precede the handshake.
  assign rsp_data   = div_result;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      rr_ptr    <= '0;
      cnt       <= '0;
      rsp_valid <= 1'b0;
      rsp_idx   <= '0;
      rsp_tag   <= '0;
    end else if (fire) begin
      state     <= ST_BUSY;
      cnt       <= CNTW'(LATENCY - 1);
      rr_ptr    <= IDXW'((32'(grant_idx) + 32'd1) % NUM_REQS);
      rsp_valid <= 1'b0;
      rsp_idx   <= grant_idx;
      rsp_tag   <= req_tag[32'(grant_idx) * TAGW +: TAGW];
    end else begin
      case (state)
        ST_BUSY: begin
          if (cnt == CNTW'(1)) begin
            state     <= ST_DONE;
            rsp_valid <= 1'b1;
          end else begin
            cnt <= cnt - CNTW'(1);
          end
        end
        ST_DONE: begin
          if (rsp_ready) begin
            state     <= ST_IDLE;
            rsp_valid <= 1'b0;
          end
        end
        ST_IDLE: begin
          rsp_valid <= 1'b0;
        end
        default: begin
          state     <= ST_IDLE;
          rsp_valid <= 1'b0;
        end
      endcase
    end
  end

  // Structural invariants of the scheduler.
  a_ready_onehot: assert property (@(posedge clk) disable iff (reset) $onehot0(req_ready));
  a_no_busy_fire: assert property (@(posedge clk) disable iff (reset) (state == ST_BUSY) |-> !fire);
  a_cnt_nonzero:  assert property (@(posedge clk) disable iff (reset) (state == ST_BUSY) |-> (cnt != '0));

endmodule

// File: tb/tb_vx_div_share_sched.sv
// Directed bench for vx_div_share_sched: a LATENCY=4 instance for the main scenarios
// and a LATENCY=2 instance for the minimum-latency corner.
module tb_vx_div_share_sched;

  localparam int unsigned N  = 4;
  localparam int unsigned DW = 128;
  localparam int unsigned RW = 64;
  localparam int unsigned TW = 16;

  logic            clk;
  logic            reset;

  logic [N-1:0]    req_valid;
  logic [N*DW-1:0] req_data;
  logic [N*TW-1:0] req_tag;
  logic [N-1:0]    req_ready;
  logic            div_strobe;
  logic [DW-1:0]   div_data;
  logic [RW-1:0]   div_result;
  logic            rsp_valid;
  logic [1:0]      rsp_idx;
  logic [TW-1:0]   rsp_tag;
  logic [RW-1:0]   rsp_data;
  logic            rsp_ready;

  logic [N-1:0]    req_valid2;
  logic [N-1:0]    req_ready2;
  logic            div_strobe2;
  logic [DW-1:0]   div_data2;
  logic [RW-1:0]   div_result2;
  logic            rsp_valid2;
  logic [1:0]      rsp_idx2;
  logic [TW-1:0]   rsp_tag2;
  logic [RW-1:0]   rsp_data2;
  logic            rsp_ready2;

  int checks;
  int errors;

  vx_div_share_sched #(
    .NUM_REQS(N), .DATAW(DW), .RESW(RW), .TAGW(TW), .LATENCY(4)
  ) u_dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_data(req_data), .req_tag(req_tag), .req_ready(req_ready),
    .div_strobe(div_strobe), .div_data(div_data), .div_result(div_result),
    .rsp_valid(rsp_valid), .rsp_idx(rsp_idx), .rsp_tag(rsp_tag), .rsp_data(rsp_data),
    .rsp_ready(rsp_ready)
  );

  vx_div_share_sched #(
    .NUM_REQS(N), .DATAW(DW), .RESW(RW), .TAGW(TW), .LATENCY(2)
  ) u_dut_lat2 (
    .clk(clk), .reset(reset),
    .req_valid(req_valid2), .req_data(req_data), .req_tag(req_tag), .req_ready(req_ready2),
    .div_strobe(div_strobe2), .div_data(div_data2), .div_result(div_result2),
    .rsp_valid(rsp_valid2), .rsp_idx(rsp_idx2), .rsp_tag(rsp_tag2), .rsp_data(rsp_data2),
    .rsp_ready(rsp_ready2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    @(negedge clk);
    @(negedge clk);
    #1;
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL reset_req_ready: got %b expected 0000", req_ready); end
    checks++; if (div_strobe !== 1'b0) begin errors++; $display("FAIL reset_div_strobe: got %b expected 0", div_strobe); end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b expected 0", rsp_valid); end
    checks++; if (rsp_idx !== 2'd0) begin errors++; $display("FAIL reset_rsp_idx: got %0d expected 0", rsp_idx); end
    checks++; if (rsp_tag !== 16'h0000) begin errors++; $display("FAIL reset_rsp_tag: got %h expected 0000", rsp_tag); end
    checks++; if (req_ready2 !== 4'b0000) begin errors++; $display("FAIL reset_req_ready2: got %b expected 0000", req_ready2); end
    checks++; if (rsp_valid2 !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid2: got %b expected 0", rsp_valid2); end
    reset      = 1'b0;
    req_valid  = '0;
    rsp_ready  = 1'b0;
    req_valid2 = '0;
    rsp_ready2 = 1'b0;
  endtask

  task automatic test_single_op();
    @(negedge clk);
    req_tag[1*TW +: TW] = 16'h0055;
    req_valid = 4'b0010;
    rsp_ready = 1'b0;
    #1;
    checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL single_req_ready: got %b expected 0010", req_ready); end
    checks++; if (div_strobe !== 1'b1) begin errors++; $display("FAIL single_strobe: got %b expected 1", div_strobe); end
    checks++; if (div_data !== {96'h0, 32'hD000_0001}) begin errors++; $display("FAIL single_div_data: got %h expected %h", div_data, {96'h0, 32'hD000_0001}); end
    for (int t = 1; t <= 3; t++) begin
      @(negedge clk);
      req_valid = '0;
      #1;
      checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL single_early_valid t%0d: got %b expected 0", t, rsp_valid); end
    end
    @(negedge clk);
    div_result = 64'h0123_4567_89AB_CDEF;
    #1;
    checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL single_rsp_valid: got %b expected 1", rsp_valid); end
    checks++; if (rsp_idx !== 2'd1) begin errors++; $display("FAIL single_rsp_idx: got %0d expected 1", rsp_idx); end
    checks++; if (rsp_tag !== 16'h0055) begin errors++; $display("FAIL single_rsp_tag: got %h expected 0055", rsp_tag); end
    checks++; if (rsp_data !== 64'h0123_4567_89AB_CDEF) begin errors++; $display("FAIL single_rsp_data: got %h expected 0123456789abcdef", rsp_data); end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    #1;
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL single_after_hs: got %b expected 0", rsp_valid); end
    // Idle with rr_ptr=2: requests offered then withdrawn before the edge.
    req_valid = 4'b0100;
    #1;
    checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL idle_grant2: got %b expected 0100", req_ready); end
    req_valid = 4'b0011;
    #1;
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL idle_wrap_grant0: got %b expected 0001", req_ready); end
    req_valid = '0;
    #1;
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL idle_no_req: got %b expected 0000", req_ready); end
    checks++; if (div_strobe !== 1'b0) begin errors++; $display("FAIL idle_no_strobe: got %b expected 0", div_strobe); end
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_rdy;
    int         exp_g;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset     = 1'b0;
    req_valid = 4'b1111;
    rsp_ready = 1'b1;
    #1;
    for (int n = 0; n < 5; n++) begin
      exp_g   = n % 4;
      exp_rdy = 4'b0001 << exp_g;
      checks++; if (req_ready !== exp_rdy) begin errors++; $display("FAIL rr_grant%0d: got %b expected %b", n, req_ready, exp_rdy); end
      checks++; if (div_strobe !== 1'b1) begin errors++; $display("FAIL rr_strobe%0d: got %b expected 1", n, div_strobe); end
      if (n > 0) begin
        checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL rr_b2b_valid%0d: got %b expected 1", n, rsp_valid); end
        checks++; if (rsp_idx !== 2'((n - 1) % 4)) begin errors++; $display("FAIL rr_b2b_idx%0d: got %0d expected %0d", n, rsp_idx, (n - 1) % 4); end
      end
      for (int t = 1; t <= 3; t++) begin
        @(negedge clk);
        if (n == 4) req_valid = '0;
        #1;
        checks++; if (div_strobe !== 1'b0) begin errors++; $display("FAIL rr_busy_strobe%0d_t%0d: got %b expected 0", n, t, div_strobe); end
      end
      @(negedge clk);
      #1;
    end
    checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL rr_last_valid: got %b expected 1", rsp_valid); end
    checks++; if (rsp_idx !== 2'd0) begin errors++; $display("FAIL rr_last_idx: got %0d expected 0", rsp_idx); end
    @(negedge clk);
    rsp_ready = 1'b0;
    #1;
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rr_drained: got %b expected 0", rsp_valid); end
  endtask

  task automatic test_backpressure();
    @(negedge clk);
    req_valid = 4'b0100;
    rsp_ready = 1'b0;
    #1;
    checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL bp_grant2: got %b expected 0100", req_ready); end
    for (int t = 1; t <= 3; t++) begin
      @(negedge clk);
      req_valid = 4'b1000;
      #1;
      checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL bp_busy_ready t%0d: got %b expected 0000", t, req_ready); end
    end
    @(negedge clk);
    div_result = 64'hCAFE_F00D_DEAD_BEEF;
    #1;
    for (int c = 0; c < 10; c++) begin
      if (c > 0) begin
        @(negedge clk);
        #1;
      end
      checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL bp_valid c%0d: got %b expected 1", c, rsp_valid); end
      checks++; if (rsp_idx !== 2'd2) begin errors++; $display("FAIL bp_idx c%0d: got %0d expected 2", c, rsp_idx); end
      checks++; if (rsp_tag !== 16'h1002) begin errors++; $display("FAIL bp_tag c%0d: got %h expected 1002", c, rsp_tag); end
      checks++; if (rsp_data !== 64'hCAFE_F00D_DEAD_BEEF) begin errors++; $display("FAIL bp_data c%0d: got %h expected cafef00ddeadbeef", c, rsp_data); end
      checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL bp_ready c%0d: got %b expected 0000", c, req_ready); end
    end
    @(negedge clk);
    rsp_ready = 1'b1;
    #1;
    checks++; if (req_ready !== 4'b1000) begin errors++; $display("FAIL bp_accept_ready: got %b expected 1000", req_ready); end
    checks++; if (div_strobe !== 1'b1) begin errors++; $display("FAIL bp_accept_strobe: got %b expected 1", div_strobe); end
    checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL bp_accept_valid: got %b expected 1", rsp_valid); end
    for (int t = 1; t <= 3; t++) begin
      @(negedge clk);
      rsp_ready = 1'b0;
      req_valid = '0;
      #1;
      checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL bp_next_busy t%0d: got %b expected 0", t, rsp_valid); end
    end
    @(negedge clk);
    #1;
    checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL bp_next_valid: got %b expected 1", rsp_valid); end
    checks++; if (rsp_idx !== 2'd3) begin errors++; $display("FAIL bp_next_idx: got %0d expected 3", rsp_idx); end
    checks++; if (rsp_tag !== 16'h1003) begin errors++; $display("FAIL bp_next_tag: got %h expected 1003", rsp_tag); end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    #1;
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL bp_drained: got %b expected 0", rsp_valid); end
  endtask

  task automatic test_wrap();
    logic [3:0] vv [3];
    int         eg [3];
    logic [3:0] exp_rdy;
    vv = '{4'b0100, 4'b1001, 4'b1001};
    eg = '{2, 3, 0};
    for (int op = 0; op < 3; op++) begin
      @(negedge clk);
      req_valid = vv[op];
      rsp_ready = 1'b1;
      #1;
      exp_rdy = 4'b0001 << eg[op];
      checks++; if (req_ready !== exp_rdy) begin errors++; $display("FAIL wrap_grant op%0d: got %b expected %b", op, req_ready, exp_rdy); end
      for (int t = 1; t <= 3; t++) begin
        @(negedge clk);
        req_valid = '0;
      end
      @(negedge clk);
      #1;
      checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL wrap_valid op%0d: got %b expected 1", op, rsp_valid); end
      checks++; if (rsp_idx !== 2'(eg[op])) begin errors++; $display("FAIL wrap_idx op%0d: got %0d expected %0d", op, rsp_idx, eg[op]); end
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    rsp_ready = 1'b0;
    req_valid = 4'b0010;
    #1;
    checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL rmid_grant1: got %b expected 0010", req_ready); end
    @(negedge clk);
    req_valid = '0;
    #1;
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rmid_t1_valid: got %b expected 0", rsp_valid); end
    @(negedge clk);
    reset = 1'b1;
    #1;
    checks++; if (div_strobe !== 1'b0) begin errors++; $display("FAIL rmid_reset_strobe: got %b expected 0", div_strobe); end
    @(negedge clk);
    reset = 1'b0;
    #1;
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rmid_t3_valid: got %b expected 0", rsp_valid); end
    checks++; if (rsp_idx !== 2'd0) begin errors++; $display("FAIL rmid_t3_idx: got %0d expected 0", rsp_idx); end
    checks++; if (rsp_tag !== 16'h0000) begin errors++; $display("FAIL rmid_t3_tag: got %h expected 0000", rsp_tag); end
    req_valid = 4'b0101;
    #1;
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL rmid_idle_grant: got %b expected 0001", req_ready); end
    req_valid = '0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      #1;
      checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rmid_no_rsp c%0d: got %b expected 0", c, rsp_valid); end
    end
  endtask

  task automatic test_min_latency();
    @(negedge clk);
    req_valid2  = 4'b0001;
    rsp_ready2  = 1'b1;
    div_result2 = 64'h0000_0000_0000_0007;
    #1;
    checks++; if (req_ready2 !== 4'b0001) begin errors++; $display("FAIL lat2_grant0: got %b expected 0001", req_ready2); end
    checks++; if (div_strobe2 !== 1'b1) begin errors++; $display("FAIL lat2_strobe0: got %b expected 1", div_strobe2); end
    @(negedge clk);
    req_valid2 = 4'b0010;
    #1;
    checks++; if (rsp_valid2 !== 1'b0) begin errors++; $display("FAIL lat2_t1_valid: got %b expected 0", rsp_valid2); end
    checks++; if (req_ready2 !== 4'b0000) begin errors++; $display("FAIL lat2_t1_ready: got %b expected 0000", req_ready2); end
    @(negedge clk);
    #1;
    checks++; if (rsp_valid2 !== 1'b1) begin errors++; $display("FAIL lat2_t2_valid: got %b expected 1", rsp_valid2); end
    checks++; if (rsp_idx2 !== 2'd0) begin errors++; $display("FAIL lat2_t2_idx: got %0d expected 0", rsp_idx2); end
    checks++; if (rsp_data2 !== 64'h7) begin errors++; $display("FAIL lat2_t2_data: got %h expected 7", rsp_data2); end
    checks++; if (req_ready2 !== 4'b0010) begin errors++; $display("FAIL lat2_b2b_ready: got %b expected 0010", req_ready2); end
    checks++; if (div_strobe2 !== 1'b1) begin errors++; $display("FAIL lat2_b2b_strobe: got %b expected 1", div_strobe2); end
    @(negedge clk);
    req_valid2 = '0;
    #1;
    checks++; if (rsp_valid2 !== 1'b0) begin errors++; $display("FAIL lat2_t3_valid: got %b expected 0", rsp_valid2); end
    @(negedge clk);
    #1;
    checks++; if (rsp_valid2 !== 1'b1) begin errors++; $display("FAIL lat2_t4_valid: got %b expected 1", rsp_valid2); end
    checks++; if (rsp_idx2 !== 2'd1) begin errors++; $display("FAIL lat2_t4_idx: got %0d expected 1", rsp_idx2); end
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      #1;
      checks++; if (rsp_valid2 !== 1'b0) begin errors++; $display("FAIL lat2_idle c%0d: got %b expected 0", c, rsp_valid2); end
    end
    rsp_ready2 = 1'b0;
  endtask

  initial begin
    checks      = 0;
    errors      = 0;
    reset       = 1'b1;
    req_valid   = 4'b1111;
    rsp_ready   = 1'b1;
    req_valid2  = 4'b1111;
    rsp_ready2  = 1'b1;
    div_result  = '0;
    div_result2 = '0;
    for (int i = 0; i < N; i++) begin
      req_data[i*DW +: DW] = {96'h0, 32'hD000_0000 | 32'(i)};
      req_tag[i*TW +: TW]  = 16'h1000 + 16'(i);
    end

    test_reset();
    test_single_op();
    test_round_robin();
    test_backpressure();
    test_wrap();
    test_reset_mid();
    test_min_latency();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
